alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//   Downstream stage of the 3-bit adder core: captures each {carry, sum} result under a valid/ready
//   handshake and buffers it in a small FIFO. Derives zero/carry flags and drives the result to the
//   ALU output/display side under its own valid/ready handshake. Keeps a wrapping count of accepted results.
// PARAMETERS
//   DATA_W   3   width of adder sum input; output result is DATA_W+1 bits (carry as MSB)
//   DEPTH    2   FIFO entries (power of two, >=2)
//   CNT_W    8   width of accepted-result counter
// PORTS
//   clk           in   1          single clock, rising edge
//   rst_n         in   1          asynchronous reset, active low
//   clr           in   1          synchronous flush: empties FIFO, zeroes counter
//   in_valid      in   1          adder result valid
//   in_ready      out  1          stage can accept (FIFO not full)
//   in_sum        in   DATA_W     adder sum bits
//   in_carry      in   1          adder carry out
//   out_valid     out  1          head entry available
//   out_ready     in   1          consumer accepts head entry
//   out_result    out  DATA_W+1   {carry, sum} of head entry (saturated if ALU_RESULT_SAT_EN)
//   out_zero      out  1          head result == 0 (all DATA_W+1 bits)
//   out_carry     out  1          head entry carry flag
//   out_sat       out  1          head entry was saturated (0 when macro absent)
//   result_count  out  CNT_W      number of accepted pushes, modulo 2^CNT_W
// BEHAVIOUR
//   Reset (rst_n=0, async): FIFO empty, in_ready=1, out_valid=0, out_result/flags=0, result_count=0.
//   Push when in_valid & in_ready; pop when out_valid & out_ready. in_ready = !full (no comb path
//     from out_ready). out_valid = !empty. No bypass: pushed entry visible at out_* next cycle (latency 1).
//   Flags computed at push time and stored with the entry: zero = ({in_carry,in_sum}==0), carry = in_carry.
//   Outputs are the registered head entry; when empty, out_result/flags hold 0.
//   Simultaneous push+pop, not empty: both occur, occupancy unchanged, order preserved (FIFO).
//   Full: in_ready=0; a pop that cycle frees a slot, in_ready rises next cycle (no same-cycle push).
//   Empty: pop ignored (out_valid=0); push-only goes to 1 entry.
//   Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1 distinguishes full/empty.
//   clr=1: next cycle FIFO empty, result_count=0; clr dominates simultaneous push/pop (push dropped,
//     not counted). Reset mid-transfer discards all entries immediately.
//   result_count += 1 per accepted push, wraps 2^CNT_W-1 -> 0 silently.
//   Input values/flags must be stable while in_valid=1 & in_ready=0 (upstream contract, asserted in bench).
// CONFIGURATION
//   ALU_RESULT_SAT_EN defined: when in_carry=1, stored result = {1'b0, {DATA_W{1'b1}}}, sat flag=1,
//     carry flag still reports 1, zero=0.
//   ALU_RESULT_SAT_EN undefined: result stored unmodified as {in_carry,in_sum}; out_sat tied 0.
// STRUCTURE
//   Shared package alu_pkg: DATA_W default constant, typedef alu_result_t {carry, zero, sat, result}
//     used by this stage and the ALU top.
//   Sub-module alu_result_fifo: generic DEPTH-entry synchronous FIFO of alu_result_t (storage,
//     wr/rd pointers, occupancy, full/empty, clr). Top handles flag derivation, saturation, counter.
// TESTING
//   Single push sum=3'b101 carry=0, out_ready=1 -> next cycle out_valid=1, out_result=4'b0101,
//     out_zero=0; pop; following cycle out_valid=0; result_count=1.
//   Push 3 entries with out_ready=0 (DEPTH=2) -> in_ready=0 after 2nd; 3rd held; release out_ready
//     -> outputs 1st,2nd,3rd in order, no loss or duplication.
//   Push sum=0 carry=0 -> out_zero=1; push sum=0 carry=1 -> out_zero=0, out_carry=1,
//     out_result=4'b1000 (macro off) / 4'b0111, out_sat=1 (macro on).
//   Continuous push+pop streaming 300 results -> one result per cycle after first, result_count=300 mod 256=44.
//   clr asserted with FIFO full and in_valid=1 -> next cycle out_valid=0, in_ready=1, result_count=0.
//   rst_n asserted low mid-stream, asynchronously between edges -> out_valid=0, result_count=0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Types shared by the ALU result path: the default adder width and the
// result entry carried from the adder core to the output/display side.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 3;

  typedef struct packed {
    logic                  carry;
    logic                  zero;
    logic                  sat;
    logic [ALU_DATA_W:0]   result;
  } alu_result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// DEPTH-entry synchronous FIFO of alu_result_t with synchronous flush.
// The head entry reads as all-zero while the FIFO is empty.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr_en,
  input  alu_result_t wr_data,
  output logic        full,
  input  logic        rd_en,
  output alu_result_t rd_data,
  output logic        empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  alu_result_t        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     occ;
  logic               push;
  logic               pop;

  assign full  = (occ == (PTR_W+1)'(DEPTH));
  assign empty = (occ == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/alu_result_stage.sv
// Adder result stage: flags each {carry, sum} at capture, buffers it in a FIFO
// and counts accepted results. Optional saturation via ALU_RESULT_SAT_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_result,
  output logic              out_zero,
  output logic              out_carry,
  output logic              out_sat,
  output logic [CNT_W-1:0]  result_count
);

  alu_result_t entry;
  alu_result_t head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    entry       = '0;
    entry.carry = in_carry;
`ifdef ALU_RESULT_SAT_EN
    if (in_carry) begin
      entry.result = {1'b0, {DATA_W{1'b1}}};
      entry.sat    = 1'b1;
    end else begin
      entry.result = {in_carry, in_sum};
    end
`else
    entry.result = {in_carry, in_sum};
`endif
    entry.zero = (entry.result == '0);
  end

  alu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (push),
    .wr_data (entry),
    .full    (full),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty)
  );

  // A flush drops any push in the same cycle, so it is not counted either.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     result_count <= '0;
    else if (clr)   result_count <= '0;
    else if (push)  result_count <= result_count + CNT_W'(1);
  end

  assign out_result = head.result;
  assign out_zero   = head.zero;
  assign out_carry  = head.carry;
  assign out_sat    = head.sat;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver queues expected entries on
// accepted pushes, a monitor pops and compares on every output handshake.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_sum = '0;
  logic       in_carry = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_result;
  logic       out_zero;
  logic       out_carry;
  logic       out_sat;
  logic [7:0] result_count;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned pops   = 0;
  logic [6:0]  exp_q[$];

  always #5 clk = ~clk;

  alu_result_stage #(
    .DATA_W (3),
    .DEPTH  (2),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_carry     (in_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_carry    (out_carry),
    .out_sat      (out_sat),
    .result_count (result_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected {result[3:0], zero, carry, sat}
  function automatic logic [6:0] model(input logic [2:0] s, input logic c);
    logic [3:0] r;
    logic       sat;
`ifdef ALU_RESULT_SAT_EN
    if (c) begin r = 4'b0111; sat = 1'b1; end
    else   begin r = {c, s};  sat = 1'b0; end
`else
    r   = {c, s};
    sat = 1'b0;
`endif
    return {r, (r == 4'b0000), c, sat};
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [2:0] s, input logic c);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) exp_q.push_back(model(s, c));
    else check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin ok = 1'b1; break; end
    end
    check("drain_done", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) check("unexpected_output", {25'd0, out_result, out_zero, out_carry, out_sat}, 32'hFFFF_FFFF);
      else check("head_entry", {25'd0, out_result, out_zero, out_carry, out_sat}, {25'd0, exp_q.pop_front()});
    end
  end

  // Upstream contract: stalled inputs stay put until accepted.
  logic       prev_stall = 1'b0;
  logic [3:0] prev_in = '0;
  always @(negedge clk) begin
    if (prev_stall && rst_n)
      check("input_stable", {27'd0, in_valid, in_carry, in_sum}, {27'd0, 1'b1, prev_in});
    prev_stall = rst_n && !clr && in_valid && !in_ready;
    prev_in    = {in_carry, in_sum};
  end

  initial begin
    int unsigned stalls;
    int unsigned pops0;

    #12;
    check("rst_in_ready",  {31'd0, in_ready},   32'd1);
    check("rst_out_valid", {31'd0, out_valid},  32'd0);
    check("rst_out_result",{28'd0, out_result}, 32'd0);
    check("rst_flags",     {29'd0, out_zero, out_carry, out_sat}, 32'd0);
    check("rst_count",     {24'd0, result_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push with latency 1
    out_ready = 1'b1;
    send(3'b101, 1'b0);
    check("single_valid",  {31'd0, out_valid},  32'd1);
    check("single_result", {28'd0, out_result}, 32'h5);
    check("single_zero",   {31'd0, out_zero},   32'd0);
    @(posedge clk); #1;
    check("single_popped", {31'd0, out_valid},  32'd0);
    check("single_count",  {24'd0, result_count}, 32'd1);

    // Backpressure: fill, hold third, release
    out_ready = 1'b0;
    send(3'd1, 1'b0);
    send(3'd2, 1'b1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    fork
      send(3'd3, 1'b0);
      begin repeat (3) @(posedge clk); #1; out_ready = 1'b1; end
    join
    drain();
    check("bp_count", {24'd0, result_count}, 32'd4);

    // Zero and carry flags
    out_ready = 1'b0;
    send(3'd0, 1'b0);
    check("zero_flag", {31'd0, out_zero}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd0, 1'b1);
    check("carry_zero",  {31'd0, out_zero},  32'd0);
    check("carry_flag",  {31'd0, out_carry}, 32'd1);
`ifdef ALU_RESULT_SAT_EN
    check("carry_result", {28'd0, out_result}, 32'h7);
    check("carry_sat",    {31'd0, out_sat},    32'd1);
`else
    check("carry_result", {28'd0, out_result}, 32'h8);
    check("carry_sat",    {31'd0, out_sat},    32'd0);
`endif
    out_ready = 1'b1;
    drain();

    // Streaming 300 results from a cleared counter
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    stalls = 0;
    pops0  = pops;
    for (int i = 0; i < 300; i++) begin
      send(3'(i), 1'((i >> 3) & 1));
      if (!out_valid || !in_ready) stalls++;
    end
    drain();
    check("stream_stalls", stalls, 32'd0);
    check("stream_pops",   pops - pops0, 32'd300);
    check("stream_count",  {24'd0, result_count}, 32'd44);

    // Flush while full with a pending push
    out_ready = 1'b0;
    send(3'd6, 1'b0);
    send(3'd7, 1'b0);
    in_valid = 1'b1; in_sum = 3'd4; in_carry = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_in_ready",  {31'd0, in_ready},  32'd1);
    check("clr_count",     {24'd0, result_count}, 32'd0);

    // Asynchronous reset between edges
    send(3'd2, 1'b0);
    send(3'd3, 1'b0);
    in_valid = 1'b1; in_sum = 3'd5; in_carry = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_count",     {24'd0, result_count}, 32'd0);
    check("arst_in_ready",  {31'd0, in_ready},  32'd1);
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd4, 1'b0);
    drain();
    check("post_rst_count", {24'd0, result_count}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
